// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage load/store sequencer; decodes funct3 into lanes and extends load data.
// Latency: beat 1 strobes the cycle after accept; resp_valid the cycle after the last mem_resp (trap: cycle after accept).
// Backpressure: req_ready is high only in IDLE; each beat holds its strobe until mem_resp.
module mem_access_ctrl #(
    parameter int XLEN           = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp,
    output logic              resp_valid,
    output logic              resp_trap,
    output logic [XLEN-1:0]   resp_rdata
);
    localparam int WB   = XLEN / 8;
    localparam int OW   = $clog2(WB);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT1 = 2'd1;
    localparam logic [1:0] BEAT2 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic              st_q;
    logic [2:0]        f3_q;
    logic [OW-1:0]     off_q;
    logic [2*WB-1:0]   m2_q;
    logic [2*XLEN-1:0] wd2_q;
    logic              split_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   lo_q;

    logic [OW-1:0]     req_off;
    logic [7:0]        req_base;
    logic [2*WB-1:0]   req_m2;
    logic [2*XLEN-1:0] req_wd2;
    logic              req_split;
    logic              req_legal;
    logic [XLEN-1:0]   req_aligned;

    // Shift the right-justified value down by the byte offset, keep n bytes, then extend.
    function automatic logic [XLEN-1:0] extend(input logic [2*XLEN-1:0] pair,
                                               input logic [OW-1:0] off,
                                               input logic [2:0] f3);
        logic [2*XLEN-1:0] sh;
        sh = pair >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   extend = f3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'b01:   extend = f3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'b10:   extend = f3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: extend = sh[XLEN-1:0];
        endcase
    endfunction

    // Request decode: lane mask over two words, shifted store data, split and legality.
    always_comb begin
        req_off     = req_addr[OW-1:0];
        req_aligned = {req_addr[XLEN-1:OW], {OW{1'b0}}};
        case (req_funct3[1:0])
            2'b00:   req_base = 8'h01;
            2'b01:   req_base = 8'h03;
            2'b10:   req_base = 8'h0F;
            default: req_base = 8'hFF;
        endcase
        req_m2    = (2*WB)'(req_base) << req_off;
        req_wd2   = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};
        req_split = |req_m2[2*WB-1:WB];
        if (req_store) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (IS64 && req_funct3 == 3'b011);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101) ||
                        (IS64 && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
        end
    end

    // Access sequencer; every output is a register so strobes drop directly on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            resp_valid      <= 1'b0;
            resp_trap       <= 1'b0;
            resp_rdata      <= '0;
            st_q            <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            m2_q            <= '0;
            wd2_q           <= '0;
            split_q         <= 1'b0;
            addr_q          <= '0;
            lo_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_q      <= req_store;
                        f3_q      <= req_funct3;
                        off_q     <= req_off;
                        m2_q      <= req_m2;
                        wd2_q     <= req_wd2;
                        split_q   <= req_split;
                        addr_q    <= req_aligned;
                        req_ready <= 1'b0;
                        if (!req_legal || (req_split && !MISALIGN_SPLIT)) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_trap  <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state           <= BEAT1;
                            mem_read        <= !req_store;
                            mem_write       <= req_store;
                            mem_address     <= req_aligned;
                            mem_byte_enable <= req_m2[WB-1:0];
                            mem_wdata       <= req_wd2[XLEN-1:0];
                        end
                    end
                end
                BEAT1: begin
                    if (mem_resp) begin
                        lo_q <= mem_rdata;
                        if (split_q) begin
                            state           <= BEAT2;
                            mem_address     <= addr_q + XLEN'(WB);
                            mem_byte_enable <= m2_q[2*WB-1:WB];
                            mem_wdata       <= wd2_q[2*XLEN-1:XLEN];
                        end else begin
                            state           <= DONE;
                            mem_read        <= 1'b0;
                            mem_write       <= 1'b0;
                            mem_byte_enable <= '0;
                            resp_valid      <= 1'b1;
                            resp_trap       <= 1'b0;
                            resp_rdata      <= st_q ? '0 :
                                extend({{XLEN{1'b0}}, mem_rdata}, off_q, f3_q);
                        end
                    end
                end
                BEAT2: begin
                    if (mem_resp) begin
                        state           <= DONE;
                        mem_read        <= 1'b0;
                        mem_write       <= 1'b0;
                        mem_byte_enable <= '0;
                        resp_valid      <= 1'b1;
                        resp_trap       <= 1'b0;
                        resp_rdata      <= st_q ? '0 : extend({mem_rdata, lo_q}, off_q, f3_q);
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_trap  <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: directed checks of mem_access_ctrl (32-bit split, 32-bit trap-on-misalign, 64-bit).
// Latency: inputs driven 1 ns after posedge, outputs sampled 1 ns after posedge.
// Backpressure: requests issued only while the target instance is idle.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic        mem_resp = 1'b0;

    logic        a_req_ready, a_mem_read, a_mem_write, a_resp_valid, a_resp_trap;
    logic [31:0] a_mem_address, a_mem_wdata, a_resp_rdata;
    logic [3:0]  a_be;
    logic        b_req_ready, b_mem_read, b_mem_write, b_resp_valid, b_resp_trap;
    logic [31:0] b_mem_address, b_mem_wdata, b_resp_rdata;
    logic [3:0]  b_be;
    logic        c_req_ready, c_mem_read, c_mem_write, c_resp_valid, c_resp_trap;
    logic [63:0] c_mem_address, c_mem_wdata, c_resp_rdata;
    logic [7:0]  c_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(a_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
        .mem_wdata(a_mem_wdata), .mem_byte_enable(a_be), .mem_rdata(mem_rdata[31:0]),
        .mem_resp(mem_resp), .resp_valid(a_resp_valid), .resp_trap(a_resp_trap),
        .resp_rdata(a_resp_rdata));

    mem_access_ctrl #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(b_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_wdata(b_mem_wdata), .mem_byte_enable(b_be), .mem_rdata(mem_rdata[31:0]),
        .mem_resp(mem_resp), .resp_valid(b_resp_valid), .resp_trap(b_resp_trap),
        .resp_rdata(b_resp_rdata));

    mem_access_ctrl #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) u_c (
        .clk(clk), .rst(rst), .req_valid(vc), .req_ready(c_req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_address(c_mem_address),
        .mem_wdata(c_mem_wdata), .mem_byte_enable(c_be), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .resp_valid(c_resp_valid), .resp_trap(c_resp_trap),
        .resp_rdata(c_resp_rdata));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One-cycle request to instance sel (0=a, 1=b, 2=c); returns 1 ns after the accept edge.
    task automatic issue(input int sel, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        @(posedge clk); #1;
        req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        va = (sel == 0); vb = (sel == 1); vc = (sel == 2);
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
    endtask

    // Wait some cycles then pulse mem_resp for one cycle; returns 1 ns after the edge that saw it.
    task automatic respond(input int wait_cyc, input logic [63:0] rd);
        repeat (wait_cyc) @(posedge clk);
        #1;
        mem_resp = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_resp = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #12;
        chk("rst_ready",  {63'd0, a_req_ready}, 64'd1);
        chk("rst_read",   {63'd0, a_mem_read}, 64'd0);
        chk("rst_rvalid", {63'd0, a_resp_valid}, 64'd0);
        chk("rst_addr",   {32'd0, a_mem_address}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // lw 0x100, response two cycles after mem_read rises
        issue(0, 1'b0, 3'b010, 64'h100, 64'h0);
        chk("lw_read",  {63'd0, a_mem_read}, 64'd1);
        chk("lw_write", {63'd0, a_mem_write}, 64'd0);
        chk("lw_addr",  {32'd0, a_mem_address}, 64'h100);
        chk("lw_be",    {60'd0, a_be}, 64'hF);
        chk("lw_busy",  {63'd0, a_req_ready}, 64'd0);
        respond(2, 64'hDEADBEEF);
        chk("lw_rvalid", {63'd0, a_resp_valid}, 64'd1);
        chk("lw_trap",   {63'd0, a_resp_trap}, 64'd0);
        chk("lw_rdata",  {32'd0, a_resp_rdata}, 64'hDEADBEEF);
        chk("lw_rd_off", {63'd0, a_mem_read}, 64'd0);
        @(posedge clk); #1;
        chk("lw_pulse",  {63'd0, a_resp_valid}, 64'd0);
        chk("lw_ready",  {63'd0, a_req_ready}, 64'd1);

        // lb / lbu at 0x103
        issue(0, 1'b0, 3'b000, 64'h103, 64'h0);
        chk("lb_be", {60'd0, a_be}, 64'h8);
        respond(0, 64'h80000000);
        chk("lb_rdata", {32'd0, a_resp_rdata}, 64'hFFFFFF80);
        issue(0, 1'b0, 3'b100, 64'h103, 64'h0);
        respond(1, 64'h80000000);
        chk("lbu_rdata", {32'd0, a_resp_rdata}, 64'h00000080);

        // sh 0x103 split into two beats
        issue(0, 1'b1, 3'b001, 64'h103, 64'h1234);
        chk("sh_b1_write", {63'd0, a_mem_write}, 64'd1);
        chk("sh_b1_read",  {63'd0, a_mem_read}, 64'd0);
        chk("sh_b1_addr",  {32'd0, a_mem_address}, 64'h100);
        chk("sh_b1_be",    {60'd0, a_be}, 64'h8);
        chk("sh_b1_wd",    {56'd0, a_mem_wdata[31:24]}, 64'h34);
        respond(0, 64'h0);
        chk("sh_b2_write", {63'd0, a_mem_write}, 64'd1);
        chk("sh_b2_addr",  {32'd0, a_mem_address}, 64'h104);
        chk("sh_b2_be",    {60'd0, a_be}, 64'h1);
        chk("sh_b2_wd",    {56'd0, a_mem_wdata[7:0]}, 64'h12);
        chk("sh_b2_nrv",   {63'd0, a_resp_valid}, 64'd0);
        respond(0, 64'h0);
        chk("sh_rvalid", {63'd0, a_resp_valid}, 64'd1);
        chk("sh_trap",   {63'd0, a_resp_trap}, 64'd0);
        chk("sh_rdata",  {32'd0, a_resp_rdata}, 64'h0);
        chk("sh_wr_off", {63'd0, a_mem_write}, 64'd0);

        // same store on the trap-on-misalign instance
        issue(1, 1'b1, 3'b001, 64'h103, 64'h1234);
        chk("shx_rvalid", {63'd0, b_resp_valid}, 64'd1);
        chk("shx_trap",   {63'd0, b_resp_trap}, 64'd1);
        chk("shx_nowr",   {63'd0, b_mem_write}, 64'd0);
        @(posedge clk); #1;
        chk("shx_pulse",  {63'd0, b_resp_valid}, 64'd0);

        // lw 0xFFFFFFFE wraps to address 0 on beat 2
        issue(0, 1'b0, 3'b010, 64'hFFFFFFFE, 64'h0);
        chk("wrap_b1_addr", {32'd0, a_mem_address}, 64'hFFFFFFFC);
        chk("wrap_b1_be",   {60'd0, a_be}, 64'hC);
        respond(0, 64'hAABBCCDD);
        chk("wrap_b2_addr", {32'd0, a_mem_address}, 64'h0);
        chk("wrap_b2_be",   {60'd0, a_be}, 64'h3);
        chk("wrap_b2_read", {63'd0, a_mem_read}, 64'd1);
        respond(1, 64'h11223344);
        chk("wrap_rdata",   {32'd0, a_resp_rdata}, 64'h3344AABB);

        // ld at XLEN=32 and illegal store funct3 both trap
        issue(0, 1'b0, 3'b011, 64'h8, 64'h0);
        chk("ld32_trap", {63'd0, a_resp_trap}, 64'd1);
        chk("ld32_rv",   {63'd0, a_resp_valid}, 64'd1);
        chk("ld32_nord", {63'd0, a_mem_read}, 64'd0);
        issue(0, 1'b1, 3'b100, 64'h0, 64'h0);
        chk("st100_trap", {63'd0, a_resp_trap}, 64'd1);

        // XLEN=64: ld 0x8 and sign-extended lw at 0xC
        issue(2, 1'b0, 3'b011, 64'h8, 64'h0);
        chk("ld64_addr", c_mem_address, 64'h8);
        chk("ld64_be",   {56'd0, c_be}, 64'hFF);
        respond(1, 64'h8123456789ABCDEF);
        chk("ld64_trap",  {63'd0, c_resp_trap}, 64'd0);
        chk("ld64_rdata", c_resp_rdata, 64'h8123456789ABCDEF);
        issue(2, 1'b0, 3'b010, 64'hC, 64'h0);
        chk("lw64_be", {56'd0, c_be}, 64'hF0);
        respond(0, 64'h8000000000000000);
        chk("lw64_rdata", c_resp_rdata, 64'hFFFFFFFF80000000);

        // reset during BEAT1 abandons the access
        issue(0, 1'b0, 3'b010, 64'h40, 64'h0);
        chk("ab_read", {63'd0, a_mem_read}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ab_rd_drop", {63'd0, a_mem_read}, 64'd0);
        chk("ab_ready",   {63'd0, a_req_ready}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("ab_no_rv", {63'd0, a_resp_valid}, 64'd0);
        end
        issue(0, 1'b0, 3'b010, 64'h200, 64'h0);
        chk("post_addr", {32'd0, a_mem_address}, 64'h200);
        respond(1, 64'h12345678);
        chk("post_rv",    {63'd0, a_resp_valid}, 64'd1);
        chk("post_rdata", {32'd0, a_resp_rdata}, 64'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
